// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Hazard and sequencing controller for the five-stage MIPS pipeline. It
// drives the en/flush pair of every pipeline latch and the PC write enable.
// It resolves data-memory waits, fetch misses, taken redirects, RAW hazards
// and the halt drain. It also keeps a saturating count of PC-stall cycles.
//
// Build option: define PIPE_FORWARDING_EN when the datapath has a forwarding
// unit. In that build only load-use stalls. Without it, any in-flight EX/MEM
// register write that matches an ID source also stalls.
//
// Ports
//   CLK, RST                      clock (rising edge), async active-high reset
//   ihit, dhit                    fetch / data access complete this cycle
//   id_rs, id_rt, id_uses_rt      source registers of the ID instruction
//   ex_RegWr, ex_dREN, ex_wsel    EX-stage register write / load / destination
//   ex_redirect                   taken branch or jump resolved in EX
//   mem_RegWr, mem_dREN, mem_dWEN MEM-stage controls
//   mem_halt, mem_wsel            MEM-stage halt flag and destination
//   pc_en                         PC write enable
//   *_en, *_flush                 latch controls (flush wins over en)
//   halt                          sticky registered halt
//   stall_cnt                     saturating count of PC-stall cycles
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_RegWr,
  input  logic             ex_dREN,
  input  logic [4:0]       ex_wsel,
  input  logic             ex_redirect,
  input  logic             mem_RegWr,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic [4:0]       mem_wsel,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

  state_t state, next_state;

  logic dstall;
  logic ex_src_match;
  logic loaduse;
  logic hazard;

  // A destination matches the ID instruction if it equals rs, or rt when rt
  // is actually read. Register 0 never matches.
  assign ex_src_match = (ex_wsel != 5'd0) &&
                        ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));
  assign dstall  = (mem_dREN | mem_dWEN) & ~dhit;
  assign loaduse = ex_dREN & ex_src_match;

`ifdef PIPE_FORWARDING_EN
  assign hazard = loaduse;

  logic unused_raw;
  assign unused_raw = ^{ex_RegWr, mem_RegWr, mem_wsel};
`else
  logic mem_src_match;

  // WB is not checked because the register file writes before it reads.
  assign mem_src_match = (mem_wsel != 5'd0) &&
                         ((mem_wsel == id_rs) || (id_uses_rt && (mem_wsel == id_rt)));
  assign hazard = loaduse | (ex_RegWr & ex_src_match) | (mem_RegWr & mem_src_match);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // The drain happens on the cycle mem_halt is seen, so the register goes
  // straight to HALTED. That gives the predecessor exactly one WB cycle. The
  // DRAIN encoding behaves the same way if it is ever entered.
  always_comb begin
    next_state  = state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    if (!RST) begin
      case (state)
        RUN, DWAIT: begin
          if (mem_halt) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_en    = 1'b1;
            next_state  = HALTED;
          end else if (dstall) begin
            memwb_flush = 1'b1;
            next_state  = DWAIT;
          end else begin
            next_state = RUN;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            if (ex_redirect) begin
              pc_en      = 1'b1;
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end else if (hazard) begin
              ifid_en    = 1'b0;
              idex_flush = 1'b1;
            end else if (!ihit) begin
              ifid_flush = 1'b1;
            end else begin
              pc_en = 1'b1;
            end
          end
        end
        DRAIN: begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          memwb_en    = 1'b1;
          next_state  = HALTED;
        end
        HALTED: begin
          next_state = HALTED;
        end
        default: begin
          next_state = RUN;
        end
      endcase
    end
  end

  // halt follows the HALTED state one cycle late. That places its rise two
  // cycles after mem_halt is first seen.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halt <= 1'b0;
    end else begin
      halt <= (state == HALTED);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (((state == RUN) || (state == DWAIT)) && !pc_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Directed vectors for pipeline_ctrl. Each vector pushes its hand-computed
// expected control word and stall count into a scoreboard queue. A monitor
// pops the queue on the falling edge and compares it with the DUT outputs.
module tb_pipeline_ctrl;

  localparam int CNT_W = 8;
`ifdef PIPE_FORWARDING_EN
  localparam int NF = 0;
`else
  localparam int NF = 1;
`endif

  // Control word order:
  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
  //  exmem_en, exmem_flush, memwb_en, memwb_flush, halt}
  localparam logic [9:0] ALL    = 10'b1111111111;
  localparam logic [9:0] ZERO   = 10'b0000000000;
  localparam logic [9:0] NORM   = 10'b1101010100;
  localparam logic [9:0] DST    = 10'b0000000010;
  localparam logic [9:0] DST_M  = 10'b1111111011;
  localparam logic [9:0] REDIR  = 10'b1111110100;
  localparam logic [9:0] HAZ    = 10'b0000110100;
  localparam logic [9:0] HAZ_M  = 10'b1110111111;
  localparam logic [9:0] MISS   = 10'b0011010100;
  localparam logic [9:0] MISS_M = 10'b1011111111;
  localparam logic [9:0] DRN    = 10'b0010101100;
  localparam logic [9:0] DRN_M  = 10'b1010101111;
  localparam logic [9:0] HLT    = 10'b0000000001;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ihit, dhit, id_uses_rt, ex_RegWr, ex_dREN, ex_redirect;
  logic mem_RegWr, mem_dREN, mem_dWEN, mem_halt;
  logic [4:0] id_rs, id_rt, ex_wsel, mem_wsel;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct {
    int               id;
    logic [9:0]       ctrl;
    logic [9:0]       mask;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sbQueue[$];
  int   vecId = 0;
  int   compared = 0;
  int   mismatched = 0;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_RegWr(ex_RegWr), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel),
    .ex_redirect(ex_redirect), .mem_RegWr(mem_RegWr), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .mem_halt(mem_halt), .mem_wsel(mem_wsel),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .halt(halt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  // Move just past the next rising edge, then restore idle inputs.
  task automatic nextCycle();
    @(posedge CLK);
    #1;
    ihit = 1'b1; dhit = 1'b0; id_uses_rt = 1'b0;
    ex_RegWr = 1'b0; ex_dREN = 1'b0; ex_redirect = 1'b0;
    mem_RegWr = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0; mem_halt = 1'b0;
    id_rs = 5'd1; id_rt = 5'd2; ex_wsel = 5'd0; mem_wsel = 5'd0;
  endtask

  task automatic applyStimulus(input logic [9:0] ctrl, input logic [9:0] mask,
                               input logic [CNT_W-1:0] cnt);
    exp_t e;
    vecId++;
    e.id = vecId; e.ctrl = ctrl; e.mask = mask; e.cnt = cnt;
    sbQueue.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [9:0] act;
    act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, exmem_flush, memwb_en, memwb_flush, halt};
    compared++;
    if ((act & e.mask) !== (e.ctrl & e.mask)) begin
      mismatched++;
      $display("[TB] FAIL vec%0d ctrl: got %b expected %b (mask %b)", e.id, act, e.ctrl, e.mask);
    end
    compared++;
    if (stall_cnt !== e.cnt) begin
      mismatched++;
      $display("[TB] FAIL vec%0d stall_cnt: got %0d expected %0d", e.id, stall_cnt, e.cnt);
    end
  endtask

  always @(negedge CLK) begin
    if (sbQueue.size() > 0) begin
      checkOutput(sbQueue.pop_front());
    end
  end

  initial begin
    nextCycle(); applyStimulus(ZERO, ALL, 0);
    nextCycle(); applyStimulus(ZERO, ALL, 0);
    nextCycle(); RST = 1'b0; applyStimulus(NORM, ALL, 0);

    // Load-use, then recovery
    nextCycle(); ex_dREN = 1'b1; ex_wsel = 5'd8; id_rs = 5'd8;
    applyStimulus(HAZ, HAZ_M, 0);
    nextCycle(); applyStimulus(NORM, ALL, 1);

    // Three data-wait cycles, then resume on dhit
    for (int i = 0; i < 3; i++) begin
      nextCycle(); mem_dREN = 1'b1;
      applyStimulus(DST, DST_M, CNT_W'(1 + i));
    end
    nextCycle(); mem_dREN = 1'b1; dhit = 1'b1; applyStimulus(NORM, ALL, 4);

    // Redirect with fetch miss
    nextCycle(); ex_redirect = 1'b1; ihit = 1'b0; applyStimulus(REDIR, ALL, 4);

    // Dstall beats redirect
    nextCycle(); mem_dWEN = 1'b1; ex_redirect = 1'b1; applyStimulus(DST, DST_M, 4);
    nextCycle(); applyStimulus(NORM, ALL, 5);

    // Fetch miss
    nextCycle(); ihit = 1'b0; applyStimulus(MISS, MISS_M, 5);
    nextCycle(); applyStimulus(NORM, ALL, 6);

    // Register 0 never stalls
    nextCycle(); id_rs = 5'd0; ex_wsel = 5'd0; ex_RegWr = 1'b1; ex_dREN = 1'b1;
    applyStimulus(NORM, ALL, 6);

    // MEM RAW on rt (stalls only without forwarding)
    nextCycle(); mem_RegWr = 1'b1; mem_wsel = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
    applyStimulus(NF ? HAZ : NORM, NF ? HAZ_M : ALL, 6);
    nextCycle(); mem_RegWr = 1'b1; mem_wsel = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b0;
    applyStimulus(NORM, ALL, CNT_W'(6 + NF));

    // EX RAW on rs (stalls only without forwarding)
    nextCycle(); ex_RegWr = 1'b1; ex_wsel = 5'd3; id_rs = 5'd3;
    applyStimulus(NF ? HAZ : NORM, NF ? HAZ_M : ALL, CNT_W'(6 + NF));
    nextCycle(); applyStimulus(NORM, ALL, CNT_W'(6 + 2 * NF));

    // Hazard has priority over a fetch miss
    nextCycle(); ex_dREN = 1'b1; ex_wsel = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; ihit = 1'b0;
    applyStimulus(HAZ, HAZ_M, CNT_W'(6 + 2 * NF));
    nextCycle(); applyStimulus(NORM, ALL, CNT_W'(7 + 2 * NF));

    // Halt: drain at N, HALTED at N+1, halt from N+2; sticky until reset
    nextCycle(); mem_halt = 1'b1; mem_dREN = 1'b1; applyStimulus(DRN, DRN_M, CNT_W'(7 + 2 * NF));
    nextCycle(); applyStimulus(ZERO, ALL, CNT_W'(8 + 2 * NF));
    nextCycle(); applyStimulus(HLT, ALL, CNT_W'(8 + 2 * NF));
    nextCycle(); ex_redirect = 1'b1; mem_dREN = 1'b1; ihit = 1'b0;
    applyStimulus(HLT, ALL, CNT_W'(8 + 2 * NF));
    nextCycle(); RST = 1'b1; applyStimulus(ZERO, ALL, 0);
    nextCycle(); RST = 1'b0; applyStimulus(NORM, ALL, 0);

    // Reset in the middle of a data wait
    nextCycle(); mem_dREN = 1'b1; applyStimulus(DST, DST_M, 0);
    nextCycle(); mem_dREN = 1'b1; RST = 1'b1; applyStimulus(ZERO, ALL, 0);
    nextCycle(); RST = 1'b0; applyStimulus(NORM, ALL, 0);
    nextCycle(); mem_dWEN = 1'b1; dhit = 1'b1; applyStimulus(NORM, ALL, 0);

    // Counter saturation
    for (int i = 0; i < 260; i++) begin
      nextCycle(); ihit = 1'b0;
      applyStimulus(MISS, MISS_M, (i > 255) ? 8'd255 : CNT_W'(i));
    end
    nextCycle(); applyStimulus(NORM, ALL, 8'd255);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 20 && sbQueue.size() > 0; i++) begin
      @(posedge CLK);
    end
    compared++;
    if (sbQueue.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sbQueue.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the five-stage pipelined MIPS datapath. It drives the `en`/`flush` pair of each pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. It resolves data-memory waits, instruction-fetch misses, taken branches/jumps, RAW hazards and the halt drain. It sits beside the pipeline registers in the datapath top level and holds the only pipeline-wide state: the FSM and a stall counter.

## Interface
- `CNT_W`, default 32: width of the stall counter.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous reset, active-high.
- `ihit` in 1: instruction fetch complete this cycle.
- `dhit` in 1: data access complete this cycle.
- `id_rs`, `id_rt` in 5: source registers of the instruction in ID.
- `id_uses_rt` in 1: ID instruction reads `rt` (R-type, branch, store).
- `ex_RegWr`, `ex_dREN` in 1: EX-stage instruction writes a register / is a load.
- `ex_wsel` in 5: EX-stage destination register, after the RegDst mux.
- `ex_redirect` in 1: taken branch or jump resolved in EX.
- `mem_RegWr`, `mem_dREN`, `mem_dWEN`, `mem_halt` in 1: MEM-stage controls.
- `mem_wsel` in 5: MEM-stage destination register.
- `pc_en` out 1: PC write enable.
- `ifid_en`, `ifid_flush` out 1: IF/ID latch controls.
- `idex_en`, `idex_flush` out 1: ID/EX latch controls.
- `exmem_en`, `exmem_flush` out 1: EX/MEM latch controls.
- `memwb_en`, `memwb_flush` out 1: MEM/WB latch controls.
- `halt` out 1: sticky halt to the system.
- `stall_cnt` out CNT_W: count of cycles with `pc_en`=0 in RUN or DWAIT.

## Operation
- Latch rule: `flush`=1 loads all-zero (bubble) regardless of `en`. Otherwise `en`=1 loads and `en`=0 holds.
- FSM states: RUN, DWAIT, DRAIN, HALTED. Reset state is RUN.
- Condition definitions:
  - dstall = (`mem_dREN`|`mem_dWEN`) & !`dhit`
  - loaduse = `ex_dREN` & `ex_wsel`≠0 & (`ex_wsel`==`id_rs` | (`id_uses_rt` & `ex_wsel`==`id_rt`))
- RUN and DWAIT. Priority from highest to lowest; the first matching row applies:
  - 1. `mem_halt`: transition to DRAIN. Outputs as in DRAIN.
  - 2. dstall: `pc_en`/`ifid_en`/`idex_en`/`exmem_en`=0, `memwb_flush`=1. State becomes DWAIT.
  - 3. `ex_redirect`: `pc_en`=1, `ifid_flush`=`idex_flush`=1, other enables 1. This applies even if `ihit`=0.
  - 4. hazard (loaduse, or RAW per Configuration): `pc_en`=`ifid_en`=0, `idex_flush`=1, `exmem_en`=`memwb_en`=1.
  - 5. !`ihit`: `pc_en`=0, `ifid_flush`=1, downstream enables 1.
  - 6. Otherwise all enables 1, all flushes 0.
  - DWAIT returns to RUN on the cycle `dhit`=1. That cycle's outputs follow rows 3–6.
- DRAIN: `pc_en`=0, `ifid_flush`=`idex_flush`=`exmem_flush`=1, `memwb_en`=1. This lasts exactly 1 cycle so the halting instruction's predecessor retires through WB. The FSM then moves to HALTED.
- HALTED: all enables 0, all flushes 0, `halt`=1. Only `RST` exits this state.
- Hazards never match on register 0.
- `stall_cnt` increments on each clock edge where the state is RUN/DWAIT and `pc_en`=0. It saturates at all-ones.

## Timing
- Control outputs are combinational from state and inputs. `halt` and `stall_cnt` are registered.
- While `RST`=1:
  - all `*_en`=0 and all `*_flush`=0
  - `halt`=0
  - `stall_cnt`=0
  - state = RUN
- Reset deassertion mid-stall resumes in RUN with no memory of the prior stall.
- Load-use costs exactly 1 bubble. A redirect costs 2 bubbles.
- `halt` rises 2 cycles after the first cycle `mem_halt`=1.

## Configuration
- `PIPE_FORWARDING_EN` defined: the forwarding unit exists. Only loaduse stalls.
- Undefined: no forwarding. The hazard condition also stalls when `ex_RegWr` & `ex_wsel` or `mem_RegWr` & `mem_wsel` (nonzero) matches `id_rs` or a used `id_rt`. WB needs no stall because the register file is write-first.

## Test plan
- Load-use: `ex_dREN`=1, `ex_wsel`=8, `id_rs`=8 → one cycle with `pc_en`=0, `idex_flush`=1. The next cycle (`ex_dREN`=0) gives all enables 1. `stall_cnt` goes 0→1.
- Data wait: `mem_dREN`=1, `dhit`=0 for 3 cycles, then 1 → 3 cycles frozen with `memwb_flush`=1 and state DWAIT, resuming on the `dhit` cycle. `stall_cnt`=3.
- Redirect with fetch miss: `ex_redirect`=1, `ihit`=0 → `pc_en`=1, `ifid_flush`=`idex_flush`=1.
- Dstall beats redirect: `mem_dWEN`=1, `dhit`=0, `ex_redirect`=1 → `pc_en`=0, no flush of IF/ID or ID/EX.
- Halt: `mem_halt`=1 at cycle N → DRAIN at N with `memwb_en`=1, HALTED at N+1, `halt`=1 from N+2. `RST` pulse → `halt`=0, state RUN.
- `$zero` and configuration: `id_rs`=0, `ex_wsel`=0, `ex_RegWr`=1 → no stall. `mem_RegWr`=1, `mem_wsel`=5, `id_rt`=5, `id_uses_rt`=1 → stall only when `PIPE_FORWARDING_EN` is undefined.
